lcd_spi_arbiter: RTL and testbench
==================================

# lcd_spi_arbiter

Shares the single ST7789 SPI link between two byte-stream requesters: requester 0 is the CPU MMIO path and requester 1 is the framebuffer refresh engine. The block grants requesters round-robin. A grant locks to one requester until its packet ends, so a command and its parameters are never interleaved with another requester's bytes. It serializes each accepted byte MSB-first on SDA/SCL in SPI mode 0 and drives DC alongside. It sits between the requesters in `main` and the `st7789_SDA/SCL/DC` pins.

## Interface
- `CLK_DIV`, default 2: SCL half-period in `clk_i` cycles. Legal values are 1..255.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `r0_valid_i` in 1: requester 0 has a byte.
- `r0_ready_o` out 1: requester 0 byte accepted this cycle when valid is also high.
- `r0_data_i` in 8: byte to send.
- `r0_dc_i` in 1: DC level for the byte (0 = command, 1 = data).
- `r0_last_i` in 1: byte ends requester 0's packet.
- `r1_valid_i`, `r1_ready_o`, `r1_data_i`, `r1_dc_i`, `r1_last_i`: identical, for requester 1.
- `sda_o` out 1: SPI data.
- `scl_o` out 1: SPI clock, idles low.
- `dc_o` out 1: data/command line.
- `busy_o` out 1: a byte is shifting.
- `grant_o` out 2: one-hot owner of the most recently accepted byte; 00 after reset.

## Operation
- FSM has two states: IDLE and SHIFT.
- **IDLE.** The grant is combinational from `rN_valid_i`, the lock and the round-robin pointer `rr`:
  - if lock is set, only the locked owner may be granted;
  - else if exactly one requester is valid, that one is granted;
  - else if both are valid, the requester selected by `rr` is granted.
- **ready.** `rN_ready_o = (state==IDLE) && granted(N)`. Ready is never high in SHIFT or during reset. Requesters must not make valid depend on ready.
- **Accept.** When valid and ready are both high:
  - latch data into the 8-bit shift register;
  - `dc_o <= dc`, `sda_o <= data[7]`, `scl_o <= 0`;
  - `grant_o <= onehot(N)`;
  - clear the half-period counter and bit counter;
  - go to SHIFT.
- **Lock and pointer update on accept.**
  - If `last=0`: lock to N.
  - If `last=1`: clear lock and set `rr` to the other requester.
  - A lone requester keeps winning regardless of `rr`.
- **SHIFT.** The half-period counter counts `CLK_DIV` cycles, then toggles `scl_o`.
  - On each falling edge the shift register shifts left and `sda_o` takes the next bit.
  - After the 8th falling edge the FSM returns to IDLE.
  - Each byte produces 8 rising edges, with SDA stable across each rising edge.
- **Holds in IDLE.** `dc_o`, `sda_o` and `grant_o` hold their values.
- **Locked owner drops valid mid-packet.** The block waits indefinitely and the other requester stalls. There is no timeout.
- **Reset.** Reset in any state, including mid-byte, aborts the byte. The partial byte is discarded and never resumed. Reset values:
  - state IDLE, lock clear, `rr` = requester 0;
  - `scl_o=0`, `sda_o=0`, `dc_o=0`, `busy_o=0`, `grant_o=00`;
  - all counters 0.

## Timing
- Accept at edge T:
  - from T+1: `busy_o=1`, `sda_o=bit7`, `dc_o` valid, `scl_o=0`;
  - SCL rises at T+1+(2k+1)·CLK_DIV and falls at T+1+(2k+2)·CLK_DIV, for k=0..7;
  - `sda_o` updates to bit(6−k) on falling edges k=0..6;
  - the 8th fall is at T+1+16·CLK_DIV. On that cycle the state is IDLE, `busy_o=0`, `scl_o=0`, and ready may assert combinationally.
- Back-to-back throughput is one byte per 16·CLK_DIV+1 cycles.
- `dc_o` changes only on accept, while `scl_o` is low.
- Latency from valid to first SDA bit is 1 cycle when IDLE and granted.

## Test plan
- **Reset state.** Hold `rst_i` 5 cycles, both valids high → both readys 0 and all outputs 0. First cycle after release → `r0_ready_o=1`, `r1_ready_o=0`.
- **Single byte, CLK_DIV=2.** r0 sends 0xA5 with dc=0, last=1 → SDA sampled on 8 SCL rises reads 1,0,1,0,0,1,0,1. `busy_o` high for exactly 32 cycles and `dc_o=0`.
- **Round-robin.** Both requesters continuously send single-byte packets (r0 0x11, r1 0x22) → wire order 11,22,11,22. `grant_o` alternates 01,10.
- **Packet lock.** r1 sends 0x2A(dc0), 0x00, 0x00, 0x00, 0xEF(dc1, last on 0xEF), with r0 valid throughout. r1 also inserts 3 idle cycles mid-packet → all 5 r1 bytes go out contiguously, then r0's byte. `dc_o` is 0 only for 0x2A.
- **Reset mid-byte.** Assert `rst_i` after the 3rd SCL rise of 0xFF → next cycle `scl_o=0`, `sda_o=0`, `busy_o=0`. After release, the next accepted byte shifts in full with no leftover bits.
- **CLK_DIV=1 throughput.** r0 streams 4 bytes → accepts are 17 cycles apart and SCL period is 2 cycles.

Source files
------------

// File: rtl/lcd_spi_arbiter_if.sv
// Byte-stream requester link into lcd_spi_arbiter.
//   valid : requester has a byte for the panel
//   ready : byte accepted this cycle when valid is also high
//   data  : byte to send, shifted out MSB first
//   dc    : DC level for the byte (0 = command, 1 = data)
//   last  : byte ends the requester's packet
// master = requester side, slave = arbiter side.
interface lcd_spi_arbiter_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;
    logic       dc;
    logic       last;

    modport master (output valid, output data, output dc, output last, input ready);
    modport slave  (input valid, input data, input dc, input last, output ready);
endinterface

// File: rtl/lcd_spi_arbiter.sv
// Round-robin arbiter and SPI mode-0 serializer for the ST7789 link.
// Two requesters (r0 = CPU MMIO, r1 = framebuffer refresh) share one SDA/SCL/DC link.
// A grant stays with one requester until it sends a byte flagged last, so a command
// and its parameters are never split by the other requester.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset; aborts any byte in flight
//   r0, r1  : requester byte streams (slave side of lcd_spi_arbiter_if)
//   sda_o   : SPI data, MSB first, changes only while scl_o is low
//   scl_o   : SPI clock, idles low, half-period CLK_DIV cycles
//   dc_o    : data/command level of the byte being shifted
//   busy_o  : a byte is shifting
//   grant_o : one-hot owner of the most recently accepted byte
module lcd_spi_arbiter #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    lcd_spi_arbiter_if.slave   r0,
    lcd_spi_arbiter_if.slave   r1,
    output logic               sda_o,
    output logic               scl_o,
    output logic               dc_o,
    output logic               busy_o,
    output logic [1:0]         grant_o
);

    localparam logic [7:0] DivMax = 8'(CLK_DIV - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e     state_q;
    logic       lock_q;
    logic       owner_q;   // locked requester index
    logic       rr_q;      // preferred requester when both are valid
    logic [7:0] div_cnt_q;
    logic [2:0] bit_cnt_q; // falling edges seen in the current byte
    logic [7:0] shift_q;
    logic       sda_q;
    logic       scl_q;
    logic       dc_q;
    logic [1:0] grant_q;

    logic gnt0, gnt1;
    logic acc0, acc1;
    logic [7:0] sel_data;
    logic       sel_dc;
    logic       sel_last;

    // Grant decision; only meaningful while idle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (lock_q) begin
            gnt0 = !owner_q && r0.valid;
            gnt1 = owner_q && r1.valid;
        end else if (r0.valid && !r1.valid) begin
            gnt0 = 1'b1;
        end else if (r1.valid && !r0.valid) begin
            gnt1 = 1'b1;
        end else if (r0.valid && r1.valid) begin
            gnt0 = !rr_q;
            gnt1 = rr_q;
        end
    end

    assign r0.ready = !rst_i && (state_q == StIdle) && gnt0;
    assign r1.ready = !rst_i && (state_q == StIdle) && gnt1;

    assign acc0 = r0.valid && r0.ready;
    assign acc1 = r1.valid && r1.ready;

    assign sel_data = acc1 ? r1.data : r0.data;
    assign sel_dc   = acc1 ? r1.dc   : r0.dc;
    assign sel_last = acc1 ? r1.last : r0.last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            lock_q    <= 1'b0;
            owner_q   <= 1'b0;
            rr_q      <= 1'b0;
            div_cnt_q <= 8'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            sda_q     <= 1'b0;
            scl_q     <= 1'b0;
            dc_q      <= 1'b0;
            grant_q   <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (acc0 || acc1) begin
                        shift_q   <= sel_data;
                        sda_q     <= sel_data[7];
                        dc_q      <= sel_dc;
                        scl_q     <= 1'b0;
                        grant_q   <= acc1 ? 2'b10 : 2'b01;
                        div_cnt_q <= 8'd0;
                        bit_cnt_q <= 3'd0;
                        state_q   <= StShift;
                        if (!sel_last) begin
                            lock_q  <= 1'b1;
                            owner_q <= acc1;
                        end else begin
                            lock_q <= 1'b0;
                            rr_q   <= !acc1;
                        end
                    end
                end
                StShift: begin
                    if (div_cnt_q == DivMax) begin
                        div_cnt_q <= 8'd0;
                        scl_q     <= !scl_q;
                        if (scl_q) begin
                            // Falling edge: present the next bit, or finish after the 8th.
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= StIdle;
                            end else begin
                                shift_q <= {shift_q[6:0], 1'b0};
                                sda_q   <= shift_q[6];
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sda_o   = sda_q;
    assign scl_o   = scl_q;
    assign dc_o    = dc_q;
    assign busy_o  = (state_q == StShift);
    assign grant_o = grant_q;

endmodule

// File: tb/tb_lcd_spi_arbiter.sv
module tb_lcd_spi_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    // Main DUT, CLK_DIV = 2
    lcd_spi_arbiter_if r0_if();
    lcd_spi_arbiter_if r1_if();
    logic       sda, scl, dc, busy;
    logic [1:0] grant;

    lcd_spi_arbiter #(.CLK_DIV(2)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .r0     (r0_if),
        .r1     (r1_if),
        .sda_o  (sda),
        .scl_o  (scl),
        .dc_o   (dc),
        .busy_o (busy),
        .grant_o(grant)
    );

    // Throughput DUT, CLK_DIV = 1
    lcd_spi_arbiter_if q0_if();
    lcd_spi_arbiter_if q1_if();
    logic       sda2, scl2, dc2, busy2;
    logic [1:0] grant2;

    lcd_spi_arbiter #(.CLK_DIV(1)) dut2 (
        .clk_i  (clk),
        .rst_i  (rst),
        .r0     (q0_if),
        .r1     (q1_if),
        .sda_o  (sda2),
        .scl_o  (scl2),
        .dc_o   (dc2),
        .busy_o (busy2),
        .grant_o(grant2)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Wire monitor: assemble bytes from SDA at SCL rises.
    logic [7:0] mon_byte_q[$];
    logic       mon_dc_q[$];
    logic [1:0] mon_grant_q[$];
    logic [7:0] cur = 8'd0;
    int         nbits = 0;
    logic       scl_prev = 1'b0;
    int         acc_q[$];
    int         r0_acc_cnt = 0;
    int unsigned acc2_q[$];
    int unsigned rise2_q[$];
    logic       scl2_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            nbits = 0;
        end else if (scl && !scl_prev) begin
            cur = {cur[6:0], sda};
            nbits++;
            if (nbits == 8) begin
                mon_byte_q.push_back(cur);
                mon_dc_q.push_back(dc);
                mon_grant_q.push_back(grant);
                nbits = 0;
            end
        end
        scl_prev = scl;
        if (r0_if.valid && r0_if.ready) begin
            acc_q.push_back(0);
            r0_acc_cnt++;
        end
        if (r1_if.valid && r1_if.ready) acc_q.push_back(1);
        if (q0_if.valid && q0_if.ready) acc2_q.push_back(cyc);
        if (scl2 && !scl2_prev) rise2_q.push_back(cyc);
        scl2_prev = scl2;
    end

    task automatic clear_logs();
        mon_byte_q.delete();
        mon_dc_q.delete();
        mon_grant_q.delete();
        acc_q.delete();
        r0_acc_cnt = 0;
        acc2_q.delete();
        rise2_q.delete();
    endtask

    task automatic idle_inputs();
        r0_if.valid = 1'b0; r0_if.data = 8'h00; r0_if.dc = 1'b0; r0_if.last = 1'b0;
        r1_if.valid = 1'b0; r1_if.data = 8'h00; r1_if.dc = 1'b0; r1_if.last = 1'b0;
        q0_if.valid = 1'b0; q0_if.data = 8'h00; q0_if.dc = 1'b0; q0_if.last = 1'b0;
        q1_if.valid = 1'b0; q1_if.data = 8'h00; q1_if.dc = 1'b0; q1_if.last = 1'b0;
    endtask

    // Ends at posedge+1 with reset released.
    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
    endtask

    // Present one byte on the main DUT and hold it until accepted.
    task automatic send(input int req, input logic [7:0] d, input logic dcv, input logic lst,
                        output bit ok);
        ok = 1'b0;
        if (req == 0) begin
            r0_if.valid = 1'b1; r0_if.data = d; r0_if.dc = dcv; r0_if.last = lst;
        end else begin
            r1_if.valid = 1'b1; r1_if.data = d; r1_if.dc = dcv; r1_if.last = lst;
        end
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (req == 0) ok = r0_if.ready;
            else          ok = r1_if.ready;
        end
        @(posedge clk);
        #1;
        if (req == 0) r0_if.valid = 1'b0;
        else          r1_if.valid = 1'b0;
    endtask

    task automatic wait_bytes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(posedge clk);
            ok = (mon_byte_q.size() >= n);
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        r0_if.valid = 1'b1; r0_if.last = 1'b1;
        r1_if.valid = 1'b1; r1_if.last = 1'b1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (r0_if.ready !== 1'b0) $display("FAIL reset_r0_ready got=%b want=0", r0_if.ready);
        else n_pass++;
        n_checks++;
        if (r1_if.ready !== 1'b0) $display("FAIL reset_r1_ready got=%b want=0", r1_if.ready);
        else n_pass++;
        n_checks++;
        if (sda !== 1'b0) $display("FAIL reset_sda got=%b want=0", sda);
        else n_pass++;
        n_checks++;
        if (scl !== 1'b0) $display("FAIL reset_scl got=%b want=0", scl);
        else n_pass++;
        n_checks++;
        if (dc !== 1'b0) $display("FAIL reset_dc got=%b want=0", dc);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy);
        else n_pass++;
        n_checks++;
        if (grant !== 2'b00) $display("FAIL reset_grant got=%b want=00", grant);
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (r0_if.ready !== 1'b1) $display("FAIL post_reset_r0_ready got=%b want=1", r0_if.ready);
        else n_pass++;
        n_checks++;
        if (r1_if.ready !== 1'b0) $display("FAIL post_reset_r1_ready got=%b want=0", r1_if.ready);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_single_byte();
        bit ok;
        int busy_cycles;
        apply_reset();
        send(0, 8'hA5, 1'b0, 1'b1, ok);
        n_checks++;
        if (!ok) $display("FAIL single_accept got=timeout want=accept");
        else n_pass++;
        busy_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cycles++;
        end
        n_checks++;
        if (busy_cycles != 32) $display("FAIL single_busy_cycles got=%0d want=32", busy_cycles);
        else n_pass++;
        wait_bytes(1, ok);
        n_checks++;
        if (!ok || mon_byte_q[0] !== 8'hA5)
            $display("FAIL single_wire_byte got=%h want=a5", ok ? mon_byte_q[0] : 8'hxx);
        else n_pass++;
        n_checks++;
        if (!ok || mon_dc_q[0] !== 1'b0) $display("FAIL single_dc got=%b want=0", ok ? mon_dc_q[0] : 1'bx);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [7:0] exp_b[4];
        logic [1:0] exp_g[4];
        exp_b = '{8'h11, 8'h22, 8'h11, 8'h22};
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        apply_reset();
        r0_if.valid = 1'b1; r0_if.data = 8'h11; r0_if.dc = 1'b1; r0_if.last = 1'b1;
        r1_if.valid = 1'b1; r1_if.data = 8'h22; r1_if.dc = 1'b1; r1_if.last = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(posedge clk);
            ok = (acc_q.size() >= 4);
        end
        #1;
        r0_if.valid = 1'b0;
        r1_if.valid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL rr_accepts got=%0d want=4", acc_q.size());
        else n_pass++;
        wait_bytes(4, ok);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (!ok || mon_byte_q[i] !== exp_b[i])
                $display("FAIL rr_byte%0d got=%h want=%h", i, ok ? mon_byte_q[i] : 8'hxx, exp_b[i]);
            else n_pass++;
            n_checks++;
            if (!ok || mon_grant_q[i] !== exp_g[i])
                $display("FAIL rr_grant%0d got=%b want=%b", i, ok ? mon_grant_q[i] : 2'bxx, exp_g[i]);
            else n_pass++;
        end
    endtask

    task automatic test_packet_lock();
        bit ok, all_ok;
        logic [7:0] exp_b[6];
        logic       exp_d[6];
        exp_b = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'hEF, 8'h33};
        exp_d = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        apply_reset();
        all_ok = 1'b1;
        send(1, 8'h2A, 1'b0, 1'b0, ok); all_ok &= ok;
        r0_if.valid = 1'b1; r0_if.data = 8'h33; r0_if.dc = 1'b1; r0_if.last = 1'b1;
        send(1, 8'h00, 1'b1, 1'b0, ok); all_ok &= ok;
        // Requester 1 goes quiet mid-packet while requester 0 keeps asking.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        repeat (3) @(posedge clk);
        #1;
        send(1, 8'h00, 1'b1, 1'b0, ok); all_ok &= ok;
        send(1, 8'h00, 1'b1, 1'b0, ok); all_ok &= ok;
        send(1, 8'hEF, 1'b1, 1'b1, ok); all_ok &= ok;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(posedge clk);
            ok = (r0_acc_cnt >= 1);
        end
        #1 r0_if.valid = 1'b0;
        all_ok &= ok;
        n_checks++;
        if (!all_ok) $display("FAIL lock_accepts got=timeout want=all_accepted");
        else n_pass++;
        wait_bytes(6, ok);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (!ok || mon_byte_q[i] !== exp_b[i])
                $display("FAIL lock_byte%0d got=%h want=%h", i, ok ? mon_byte_q[i] : 8'hxx, exp_b[i]);
            else n_pass++;
            n_checks++;
            if (!ok || mon_dc_q[i] !== exp_d[i])
                $display("FAIL lock_dc%0d got=%b want=%b", i, ok ? mon_dc_q[i] : 1'bx, exp_d[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_byte();
        bit ok;
        int rises;
        logic prev;
        apply_reset();
        send(0, 8'hFF, 1'b1, 1'b1, ok);
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < 200 && rises < 3; i++) begin
            @(negedge clk);
            if (scl && !prev) rises++;
            prev = scl;
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (scl !== 1'b0) $display("FAIL midrst_scl got=%b want=0", scl);
        else n_pass++;
        n_checks++;
        if (sda !== 1'b0) $display("FAIL midrst_sda got=%b want=0", sda);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL midrst_busy got=%b want=0", busy);
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        send(0, 8'h3C, 1'b1, 1'b1, ok);
        wait_bytes(1, ok);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (mon_byte_q.size() != 1) $display("FAIL midrst_count got=%0d want=1", mon_byte_q.size());
        else n_pass++;
        n_checks++;
        if (!ok || mon_byte_q[0] !== 8'h3C)
            $display("FAIL midrst_byte got=%h want=3c", ok ? mon_byte_q[0] : 8'hxx);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        apply_reset();
        q0_if.valid = 1'b1; q0_if.data = 8'hC3; q0_if.dc = 1'b1; q0_if.last = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(posedge clk);
            ok = (acc2_q.size() >= 4);
        end
        #1 q0_if.valid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL b2b_accepts got=%0d want=4", acc2_q.size());
        else n_pass++;
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (!ok || acc2_q[i] - acc2_q[i-1] != 17)
                $display("FAIL b2b_gap%0d got=%0d want=17", i, ok ? acc2_q[i] - acc2_q[i-1] : 0);
            else n_pass++;
        end
        n_checks++;
        if (rise2_q.size() < 2 || rise2_q[1] - rise2_q[0] != 2)
            $display("FAIL b2b_scl_period got=%0d want=2",
                     rise2_q.size() < 2 ? 0 : rise2_q[1] - rise2_q[0]);
        else n_pass++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_reset_mid_byte();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
